// File: rtl/psram_bist_if.sv
// psram_bist_if -- user-side bus between the BIST engine and the PSRAM controller.
//   init_calib     controller calibration complete (controller -> BIST)
//   cmd / cmd_en   1 = write, 0 = read; one-cycle command strobe
//   addr           command address
//   wr_data        write beat, data_mask held at 0
//   rd_data / rd_data_valid  read return beats
// master = BIST side, slave = controller / memory model side.
interface psram_bist_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 21
);
  logic                init_calib;
  logic                cmd;
  logic                cmd_en;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] data_mask;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_data_valid;

  modport master (
    input  init_calib, rd_data, rd_data_valid,
    output cmd, cmd_en, addr, wr_data, data_mask
  );

  modport slave (
    output init_calib, rd_data, rd_data_valid,
    input  cmd, cmd_en, addr, wr_data, data_mask
  );
endinterface

// File: rtl/psram_bist.sv
// psram_bist -- write/read-back self test for a PSRAM controller user port.
// Writes NUM_BURSTS bursts of a selectable pattern, reads them back and
// counts mismatched or missing beats.
//   sys_clk, sys_rst_n   clock; async active-low reset, released synchronously
//   start, pattern_sel   begin a test (idle/done only); 0 addr-tag, 1 ~addr-tag,
//                        2 LFSR, 3 checkerboard
//   busy, done, pass     status; err_count saturating mismatch count
//   bus                  controller user interface (master modport)
// Optional: define PSRAM_BIST_ERRLOG_EN to add first_err_addr/beat/data/valid,
// which capture the first data mismatch of a run.
//
// state    | meaning
// IDLE     | waiting for start
// WAIT_CAL | waiting for init_calib (and command spacing) before the pass
// WR_BURST | issuing a write command and streaming its beats
// WR_GAP   | holding off until the next command may issue
// RD_CMD   | one-cycle read command
// RD_DATA  | comparing returned beats, bounded by RD_TIMEOUT
// RD_GAP   | spacing before next read; realigns LFSR after missing beats
// DONE     | result held until next start
module psram_bist #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 21,
  parameter int BURST_BEATS = 16,
  parameter int ADDR_STEP   = 32,
  parameter int NUM_BURSTS  = 4,
  parameter int CMD_GAP     = 26,
  parameter int RD_TIMEOUT  = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
`ifdef PSRAM_BIST_ERRLOG_EN
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [4:0]        first_err_beat,
  output logic [DATA_W-1:0] first_err_data,
  output logic              first_err_valid,
`endif
  psram_bist_if.master      bus
);
  localparam int BEAT_W = 6;
  localparam int CMD_W  = $clog2(NUM_BURSTS + 1);
  localparam int TMR_W  = 16;

  typedef enum logic [2:0] {
    IDLE, WAIT_CAL, WR_BURST, WR_GAP, RD_CMD, RD_DATA, RD_GAP, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        pat_q, pat_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_next;
  logic [CMD_W-1:0]  cmd_idx_q, cmd_idx_d;
  logic [BEAT_W-1:0] beat_q, beat_d, rx_cnt;
  logic [TMR_W-1:0]  gap_q, gap_d, tmo_q, tmo_d;
  logic [31:0]       lfsr_q, lfsr_d, lfsr_step;
  logic [15:0]       err_q, err_d;
  logic              cal_lost_q, cal_lost_d;
  logic [BEAT_W:0]   err_inc;
  logic [16:0]       err_sum;
  logic [DATA_W-1:0] pat_word, tag_word;
  logic              mismatch, start_acc, last_cmd, in_run;

  // Deassertion of the reset is retimed to sys_clk; assertion stays immediate.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // x^32 + x^22 + x^2 + x + 1, shifting towards the MSB.
  assign lfsr_step = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign tag_word  = {(DATA_W/2)'(addr_q), (DATA_W/2)'(beat_q)};
  assign last_cmd  = (cmd_idx_q == CMD_W'(NUM_BURSTS - 1));
  assign addr_next = last_cmd ? '0 : addr_q + ADDR_W'(ADDR_STEP);
  assign rx_cnt    = beat_q + {{(BEAT_W-1){1'b0}}, bus.rd_data_valid};
  assign in_run    = (state_q != IDLE) && (state_q != DONE) && (state_q != WAIT_CAL);

  always_comb begin
    unique case (pat_q)
      2'd0:    pat_word = tag_word;
      2'd1:    pat_word = ~tag_word;
      2'd2:    pat_word = {(DATA_W/32){lfsr_q}};
      default: pat_word = (beat_q[0] ^ cmd_idx_q[0]) ? {(DATA_W/8){8'h55}}
                                                      : {(DATA_W/8){8'hAA}};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    addr_d      = addr_q;
    cmd_idx_d   = cmd_idx_q;
    beat_d      = beat_q;
    lfsr_d      = lfsr_q;
    err_d       = err_q;
    gap_d       = (gap_q != '0) ? gap_q - TMR_W'(1) : gap_q;
    tmo_d       = (tmo_q != '0) ? tmo_q - TMR_W'(1) : tmo_q;
    cal_lost_d  = cal_lost_q | (in_run & ~bus.init_calib);
    err_inc     = '0;
    mismatch    = 1'b0;
    start_acc   = 1'b0;
    bus.cmd     = 1'b0;
    bus.cmd_en  = 1'b0;
    bus.wr_data = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_acc  = 1'b1;
          state_d    = WAIT_CAL;
          pat_d      = pattern_sel;
          addr_d     = '0;
          cmd_idx_d  = '0;
          beat_d     = '0;
          err_d      = '0;
          cal_lost_d = 1'b0;
        end
      end
      WAIT_CAL: begin
        cal_lost_d = 1'b0;
        if (bus.init_calib && gap_q == '0) begin
          state_d = WR_BURST;
          lfsr_d  = 32'h1;
        end
      end
      WR_BURST: begin
        bus.cmd     = (beat_q == '0);
        bus.cmd_en  = (beat_q == '0);
        bus.wr_data = pat_word;
        lfsr_d      = lfsr_step;
        // Load CMD_GAP-2 so the follow-on command lands exactly CMD_GAP after this one.
        if (beat_q == '0) gap_d = TMR_W'(CMD_GAP - 2);
        if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
          beat_d    = '0;
          addr_d    = addr_next;
          cmd_idx_d = cmd_idx_q + CMD_W'(1);
          state_d   = WR_GAP;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      WR_GAP: begin
        if (gap_q == '0) begin
          if (cal_lost_q) begin
            state_d   = WAIT_CAL;
            addr_d    = '0;
            cmd_idx_d = '0;
            err_d     = '0;
          end else if (cmd_idx_q == CMD_W'(NUM_BURSTS)) begin
            state_d   = RD_CMD;
            cmd_idx_d = '0;
            lfsr_d    = 32'h1;
          end else begin
            state_d = WR_BURST;
          end
        end
      end
      RD_CMD: begin
        bus.cmd_en = 1'b1;
        gap_d      = TMR_W'(CMD_GAP - 2);
        tmo_d      = TMR_W'(RD_TIMEOUT - 1);
        beat_d     = '0;
        state_d    = RD_DATA;
      end
      RD_DATA: begin
        if (bus.rd_data_valid) begin
          lfsr_d   = lfsr_step;
          mismatch = (bus.rd_data != pat_word);
          beat_d   = rx_cnt;
        end
        if (rx_cnt == BEAT_W'(BURST_BEATS) || tmo_q == '0) begin
          err_inc   = (BEAT_W+1)'(BURST_BEATS) - {1'b0, rx_cnt};
          addr_d    = addr_next;
          cmd_idx_d = cmd_idx_q + CMD_W'(1);
          state_d   = RD_GAP;
        end
        err_inc = err_inc + {{BEAT_W{1'b0}}, mismatch};
      end
      RD_GAP: begin
        // Step the LFSR past beats that never arrived so later reads stay aligned.
        if (beat_q != BEAT_W'(BURST_BEATS)) begin
          beat_d = beat_q + BEAT_W'(1);
          lfsr_d = lfsr_step;
        end else if (gap_q == '0 && !bus.rd_data_valid) begin
          if (cal_lost_q) begin
            state_d   = WAIT_CAL;
            addr_d    = '0;
            cmd_idx_d = '0;
            beat_d    = '0;
            err_d     = '0;
          end else if (cmd_idx_q == CMD_W'(NUM_BURSTS)) begin
            state_d = DONE;
          end else begin
            state_d = RD_CMD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    err_sum = {1'b0, err_q} + 17'(err_inc);
    if (err_inc != '0) err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pat_q      <= 2'd0;
      addr_q     <= '0;
      cmd_idx_q  <= '0;
      beat_q     <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      lfsr_q     <= 32'h1;
      err_q      <= '0;
      cal_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      addr_q     <= addr_d;
      cmd_idx_q  <= cmd_idx_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      lfsr_q     <= lfsr_d;
      err_q      <= err_d;
      cal_lost_q <= cal_lost_d;
    end
  end

`ifdef PSRAM_BIST_ERRLOG_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_addr  <= '0;
      first_err_beat  <= '0;
      first_err_data  <= '0;
      first_err_valid <= 1'b0;
    end else if (start_acc) begin
      first_err_addr  <= '0;
      first_err_beat  <= '0;
      first_err_data  <= '0;
      first_err_valid <= 1'b0;
    end else if (mismatch && !first_err_valid) begin
      first_err_addr  <= addr_q;
      first_err_beat  <= beat_q[4:0];
      first_err_data  <= bus.rd_data;
      first_err_valid <= 1'b1;
    end
  end
`endif

  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = (state_q == DONE);
  assign pass          = done && (err_q == '0);
  assign err_count     = err_q;
  assign bus.addr      = addr_q;
  assign bus.data_mask = '0;
endmodule

// File: doc/psram_bist.md
PSRAM_BIST -- requirements
Module: psram_bist

Interface
REQ-001 Parameter: DATA_W, 64, user data width to the PSRAM controller.
REQ-002 Parameter: ADDR_W, 21, controller address width.
REQ-003 Parameter: BURST_BEATS, 16, data beats per command (2..32).
REQ-004 Parameter: ADDR_STEP, 32, address increment per command.
REQ-005 Parameter: NUM_BURSTS, 4, commands per pass (1..2^ADDR_W/ADDR_STEP).
REQ-006 Parameter: CMD_GAP, 26, minimum cycles from one cmd_en to the next.
REQ-007 Parameter: RD_TIMEOUT, 64, cycles after a read cmd_en within which all beats must arrive.
REQ-008 Port: sys_clk  in  1  system clock, same domain as the controller user side.
REQ-009 Port: sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-010 Port: start  in  1  one-cycle pulse, begins a test; ignored unless idle or done.
REQ-011 Port: pattern_sel  in  2  0 address-tag, 1 inverted address-tag, 2 LFSR, 3 checkerboard.
REQ-012 Port: busy / done / pass  out  1 each  test running / test finished / finished with zero errors.
REQ-013 Port: err_count  out  16  mismatched beats, saturating.
REQ-014 Port: init_calib  in  1  controller calibration complete.
REQ-015 Port: cmd, cmd_en  out  1 each  1 = write, 0 = read; one-cycle command strobe.
REQ-016 Port: addr  out  ADDR_W  command address.
REQ-017 Port: wr_data  out  DATA_W  write beat; data_mask  out  DATA_W/8  constant 0.
REQ-018 Port: rd_data  in  DATA_W, rd_data_valid  in  1  read return beats.

Function
REQ-019 States: IDLE, WAIT_CAL, WR_BURST, WR_GAP, RD_CMD, RD_DATA, RD_GAP, DONE.
REQ-020 IDLE/DONE + start -> WAIT_CAL; pattern_sel is latched on the start cycle.
REQ-021 WAIT_CAL -> WR_BURST on the first cycle init_calib = 1.
REQ-022 WR_BURST: cmd_en = 1 and cmd = 1 on beat 0; wr_data carries beat b (0..BURST_BEATS-1) on consecutive cycles, with beat 0 coincident with cmd_en.
REQ-023 WR_GAP: wr_data = 0; the next command issues exactly CMD_GAP cycles after the previous cmd_en.
REQ-024 After NUM_BURSTS writes, addr returns to 0 -> RD_CMD.
REQ-025 RD_CMD: one-cycle cmd_en with cmd = 0 -> RD_DATA.
REQ-026 RD_DATA: each rd_data_valid beat is compared with the regenerated expected beat b; a mismatch increments err_count, saturating at 16'hFFFF.
REQ-027 RD_DATA exits after BURST_BEATS beats, or on timeout; each missing beat counts as one error.
REQ-028 RD_GAP: the next read issues no sooner than CMD_GAP cycles after the previous cmd_en, and only with rd_data_valid = 0.
REQ-029 After NUM_BURSTS reads -> DONE: done = 1 and pass = (err_count == 0), both held until the next start.
REQ-030 Address for command k = k*ADDR_STEP, truncated to ADDR_W; wrap-around is permitted.
REQ-031 Pattern 0: {addr zero-extended to DATA_W/2, beat index zero-extended to DATA_W/2}.
REQ-032 Pattern 1: bitwise inverse of pattern 0.
REQ-033 Pattern 2: 32-bit Fibonacci LFSR (x^32+x^22+x^2+x+1), seed 32'h1, replicated across DATA_W, advanced once per beat.
REQ-034 Pattern 2: the LFSR is reseeded at the first write and at the first read so both phases produce identical sequences.
REQ-035 Pattern 3: 0xAA.. on even beats and 0x55.. on odd beats, with parity inverted on odd-numbered commands.
REQ-036 rd_data_valid outside RD_DATA is ignored and is not counted.
REQ-037 start while busy = 1 is ignored.
REQ-038 init_calib falling while busy: the current command completes, then the FSM returns to WAIT_CAL and restarts the pass from address 0 with err_count cleared.

Reset
REQ-039 Asynchronous assertion, synchronous deassertion to sys_clk.
REQ-040 Reset mid-operation aborts immediately with no further cmd_en.
REQ-041 Reset values: state IDLE; busy, done, pass, cmd, cmd_en = 0; addr, wr_data, err_count = 0.

Configuration
REQ-042 Macro PSRAM_BIST_ERRLOG_EN defined: adds outputs first_err_addr (ADDR_W), first_err_beat (5), first_err_data (DATA_W) and first_err_valid (1).
REQ-043 With the macro, these outputs capture the first mismatch of a run, hold until the next start and reset to 0.
REQ-044 Macro undefined: these ports and their registers do not exist; all other behaviour is identical.

Verification
REQ-045 Ideal memory model, pattern 0, defaults -> 4 writes at addr 0/32/64/96, cmd_en spacing exactly 26 cycles; then done = 1, pass = 1, err_count = 0.
REQ-046 Model flips bit 3 of beat 5 at addr 32 -> err_count = 1, pass = 0; with ERRLOG_EN: first_err_addr = 32, first_err_beat = 5.
REQ-047 Model drops the last beat of read 2 -> timeout after 64 cycles, err_count = 1, FSM proceeds to read 3.
REQ-048 Pattern 2, then pattern 3 -> pass = 1 both runs; wr_data beat 0 of command 0 = 0x0000000100000001 for pattern 2 and 0xAAAA_AAAA_AAAA_AAAA for pattern 3.
REQ-049 sys_rst_n low during WR_BURST beat 7 -> cmd_en = 0 next cycle, all outputs at reset values; a new start completes with pass = 1.
REQ-050 init_calib held 0 for 100 cycles after start -> busy = 1, no cmd_en; first cmd_en on the cycle after init_calib rises.
